seq_stream_tx: RTL

Serial pattern transmitter that drives bit streams into the team's Mealy sequence detectors. It accepts a parallel word and a bit length through a start/ready handshake, then shifts the word out MSB-first, one bit per clock, with a valid qualifier. It replaces hand-written stimulus loops in benches and also sits on-chip as a loopback source in front of `seq_detect_*` blocks.

---
 rtl/seq_pkg.sv | 16 +
 rtl/seq_bit_counter.sv | 37 +++
 rtl/seq_stream_tx.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and defaults for the seq_* stream/detector family
package seq_pkg;

  // Default frame width shared by the detectors and the transmitter.
  localparam int SEQ_WIDTH = 11;

  // Legacy-compatible state encodings; the enum below reuses them.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } seq_tx_state_t;

endpackage

// File: rtl/seq_bit_counter.sv
// rtl/seq_bit_counter.sv - loadable down-counter with a last-bit flag
module seq_bit_counter #(
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [LW-1:0] load_val,
  input  logic          dec,
  output logic          last
);

  logic [LW-1:0] cnt_q;
  logic [LW-1:0] cnt_d;

  // Load wins over decrement so a looping frame can reload on its final bit.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register; cleared asynchronously so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == {{(LW-1){1'b0}}, 1'b1});

endmodule

// File: rtl/seq_stream_tx.sv
// rtl/seq_stream_tx.sv - MSB-first serial frame transmitter; optional SEQ_TX_LOOP_EN repeats frames
module seq_stream_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int LW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [LW-1:0]    len,
`ifdef SEQ_TX_LOOP_EN
  input  logic             loop,
`endif
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  seq_tx_state_t    state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LW-1:0]    eff_len;
  logic [WIDTH-1:0] aligned;
  logic             cnt_load;
  logic [LW-1:0]    cnt_load_val;
  logic             cnt_dec;
  logic             cnt_last;
  logic             done_d;
  logic             dout_q, valid_q, busy_q, done_q;
`ifdef SEQ_TX_LOOP_EN
  logic [WIDTH-1:0] word_q, word_d;
  logic [LW-1:0]    len_q, len_d;
`endif

  // Over-long requests are clamped to the physical register width.
  assign eff_len = (len > LW'(WIDTH)) ? LW'(WIDTH) : len;

  // Left-justify the frame so the first bit always sits at the top of the shift register.
  assign aligned = data << (LW'(WIDTH) - eff_len);

  seq_bit_counter #(
    .LW(LW)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(cnt_load_val),
    .dec     (cnt_dec),
    .last    (cnt_last)
  );

  // Next-state logic for the FSM, shift register and done pulse.
  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_load     = 1'b0;
    cnt_load_val = eff_len;
    cnt_dec      = 1'b0;
    done_d       = 1'b0;
`ifdef SEQ_TX_LOOP_EN
    word_d       = word_q;
    len_d        = len_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          if (eff_len == '0) begin
            // Empty frame: acknowledge with done but never leave IDLE.
            done_d = 1'b1;
          end else begin
            sreg_d   = aligned;
            cnt_load = 1'b1;
            state_d  = SHIFT;
`ifdef SEQ_TX_LOOP_EN
            word_d   = aligned;
            len_d    = eff_len;
`endif
          end
        end
      end
      SHIFT: begin
        sreg_d  = sreg_q << 1;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
          sreg_d  = '0;
`ifdef SEQ_TX_LOOP_EN
          if (loop) begin
            // Back-to-back repeat: reload from the saved copy, no idle gap.
            state_d      = SHIFT;
            sreg_d       = word_q;
            cnt_load     = 1'b1;
            cnt_load_val = len_q;
          end
`endif
        end
      end
      default: begin
        state_d = IDLE;
        sreg_d  = '0;
      end
    endcase
  end

  // State, shift register and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dout_q  <= (state_d == SHIFT) & sreg_d[WIDTH-1];
      valid_q <= (state_d == SHIFT);
      busy_q  <= (state_d == SHIFT);
      done_q  <= done_d;
    end
  end

`ifdef SEQ_TX_LOOP_EN
  // Saved copy of the accepted frame for looping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q <= '0;
      len_q  <= '0;
    end else begin
      word_q <= word_d;
      len_q  <= len_d;
    end
  end
`endif

  assign ready      = (state_q == IDLE);
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
